// File: rtl/mlu_pkg.sv
// Shared definitions for the MLU datapath stages.
//   acc_state_e    : accumulation stage FSM states
//   MLU_*          : default datapath widths
//   sat_add_signed : signed saturating add at default accumulator width,
//                    returns {ovf, sum}
package mlu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT
  } acc_state_e;

  localparam int unsigned MLU_WIDTH     = 16;
  localparam int unsigned MLU_ACC_WIDTH = 32;
  localparam int unsigned MLU_LEN_WIDTH = 8;

  function automatic logic [MLU_ACC_WIDTH:0] sat_add_signed(
    input logic [MLU_ACC_WIDTH-1:0] a,
    input logic [MLU_ACC_WIDTH-1:0] b
  );
    logic [MLU_ACC_WIDTH:0] s;
    s = {a[MLU_ACC_WIDTH-1], a} + {b[MLU_ACC_WIDTH-1], b};
    // Top two bits disagree only when the true sum left the representable range;
    // the extra sign bit tells which limit to clamp to.
    if (s[MLU_ACC_WIDTH] != s[MLU_ACC_WIDTH-1])
      return {1'b1, s[MLU_ACC_WIDTH], {(MLU_ACC_WIDTH-1){~s[MLU_ACC_WIDTH]}}};
    return {1'b0, s[MLU_ACC_WIDTH-1:0]};
  endfunction

endpackage

// File: rtl/mlu_sat_adder.sv
// Combinational signed saturating adder: sign-extends a WIDTH-bit addend onto
// an ACC_WIDTH-bit accumulator operand and clamps the result to the signed
// ACC_WIDTH range.
//   acc    : signed accumulator operand
//   addend : signed narrow operand
//   sum    : saturated result
//   ovf    : high when the result was clamped
module mlu_sat_adder
  import mlu_pkg::*;
#(
  parameter int unsigned WIDTH     = MLU_WIDTH,
  parameter int unsigned ACC_WIDTH = MLU_ACC_WIDTH
) (
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]     addend,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 ovf
);

  logic [ACC_WIDTH:0] wide;

  always_comb begin
    wide = {acc[ACC_WIDTH-1], acc}
         + {{(ACC_WIDTH+1-WIDTH){addend[WIDTH-1]}}, addend};
    ovf  = wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1];
    if (ovf)
      sum = {wide[ACC_WIDTH], {(ACC_WIDTH-1){~wide[ACC_WIDTH]}}};
    else
      sum = wide[ACC_WIDTH-1:0];
  end

endmodule

// File: rtl/mlu_acc_stage.sv
// Accumulation stage behind the 16-input adder tree. A start in IDLE latches
// the job length and bias; each accepted tree sum is added with saturation;
// after the last sum the result is held until the downstream accepts it.
//   clk, rst            : clock, synchronous active-high reset
//   start               : job start, sampled only in IDLE
//   cfg_len, cfg_bias   : job length and bias, latched on accepted start
//   in_valid/in_ready   : tree sum handshake, in_data signed sum
//   out_valid/out_ready : result handshake, out_data signed result
//   out_ovf             : job saturated at least once, valid with out_valid
//   busy                : state is not IDLE
module mlu_acc_stage
  import mlu_pkg::*;
#(
  parameter int unsigned WIDTH     = MLU_WIDTH,
  parameter int unsigned ACC_WIDTH = MLU_ACC_WIDTH,
  parameter int unsigned LEN_WIDTH = MLU_LEN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  input  logic [WIDTH-1:0]     cfg_bias,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_ovf,
  output logic                 busy
);

  acc_state_e           state;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] sum;
  logic [ACC_WIDTH-1:0] bias_ext;
  logic [LEN_WIDTH-1:0] count;
  logic [LEN_WIDTH-1:0] len;
  logic                 ovf;
  logic                 add_ovf;
  logic                 last;

  mlu_sat_adder #(
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_sat_adder (
    .acc    (acc),
    .addend (in_data),
    .sum    (sum),
    .ovf    (add_ovf)
  );

  assign bias_ext = {{(ACC_WIDTH-WIDTH){cfg_bias[WIDTH-1]}}, cfg_bias};
  // len is never 0 while in ACC, so len-1 cannot wrap.
  assign last     = (count == len - LEN_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      count    <= '0;
      len      <= '0;
      ovf      <= 1'b0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= bias_ext;
            count <= '0;
            len   <= cfg_len;
            ovf   <= 1'b0;
            if (cfg_len != '0) begin
              state <= ACC;
            end else begin
              state    <= OUT;
              out_data <= bias_ext;
            end
          end
        end
        ACC: begin
          // in_ready is high throughout ACC, so in_valid alone marks a transfer.
          if (in_valid) begin
            acc   <= sum;
            count <= count + LEN_WIDTH'(1);
            ovf   <= ovf | add_ovf;
            if (last) begin
              out_data <= sum;
              state    <= OUT;
            end
          end
        end
        OUT: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ACC);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign out_ovf   = ovf && (state == OUT);

endmodule

// File: tb/tb_mlu_acc_stage.sv
module tb_mlu_acc_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  cfg_len;
  logic [15:0] cfg_bias;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_ovf_a, busy_a;
  logic [31:0] out_data_a;
  logic        in_ready_b, out_valid_b, out_ovf_b, busy_b;
  logic [16:0] out_data_b;

  int checks = 0;
  int errors = 0;
  logic [15:0] q[$];

  always #5 clk = ~clk;

  mlu_acc_stage #(.WIDTH(16), .ACC_WIDTH(32), .LEN_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_bias(cfg_bias),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_ovf(out_ovf_a), .busy(busy_a)
  );

  mlu_acc_stage #(.WIDTH(16), .ACC_WIDTH(17), .LEN_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_bias(cfg_bias),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_ovf(out_ovf_b), .busy(busy_b)
  );

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: integer running sum with clamping after every addition.
  task automatic model(input logic [15:0] bias, input int aw,
                       output logic [63:0] res, output logic ovf);
    longint hi, lo, a;
    hi  = (longint'(1) <<< (aw - 1)) - 1;
    lo  = -(longint'(1) <<< (aw - 1));
    a   = longint'($signed(bias));
    ovf = 1'b0;
    foreach (q[i]) begin
      a = a + longint'($signed(q[i]));
      if (a > hi) begin a = hi; ovf = 1'b1; end
      else if (a < lo) begin a = lo; ovf = 1'b1; end
    end
    res = 64'(a) & ((64'd1 << aw) - 64'd1);
  endtask

  task automatic run_job(input logic [15:0] bias, input int gap, input int hold,
                         input bit noise, input bit hs_start);
    logic [63:0] ea, eb;
    logic        oa, ob;
    model(bias, 32, ea, oa);
    model(bias, 17, eb, ob);
    cfg_bias = bias;
    cfg_len  = 8'(q.size());
    start    = 1'b1;
    tick();
    start    = 1'b0;
    check("busy_after_start", 64'(busy_a), 64'd1);
    foreach (q[i]) begin
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        tick();
        check("stall_no_out", 64'(out_valid_a), 64'd0);
      end
      in_valid = 1'b1;
      in_data  = q[i];
      if (noise) begin
        start   = 1'b1;
        cfg_len = 8'd9;
      end
      check("in_ready_acc", 64'(in_ready_a), 64'd1);
      tick();
      start = 1'b0;
    end
    // Offered data during OUT must not be taken.
    in_valid = 1'b1;
    in_data  = 16'h1234;
    check("out_valid_a", 64'(out_valid_a), 64'd1);
    check("out_valid_b", 64'(out_valid_b), 64'd1);
    check("in_ready_out", 64'(in_ready_a), 64'd0);
    check("out_data_a", 64'(out_data_a), ea);
    check("out_data_b", 64'(out_data_b), eb);
    check("out_ovf_a", 64'(out_ovf_a), 64'(oa));
    check("out_ovf_b", 64'(out_ovf_b), 64'(ob));
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", 64'(out_valid_a), 64'd1);
      check("hold_data_a", 64'(out_data_a), ea);
      check("hold_data_b", 64'(out_data_b), eb);
      check("hold_ovf_b", 64'(out_ovf_b), 64'(ob));
      check("hold_in_ready", 64'(in_ready_b), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (hs_start) begin
      start   = 1'b1;
      cfg_len = 8'd1;
    end
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    check("idle_after_hs_a", 64'(busy_a), 64'd0);
    check("idle_after_hs_b", 64'(busy_b), 64'd0);
    check("no_valid_after_hs", 64'(out_valid_a), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_len = '0; cfg_bias = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready_a), 64'd0);
    check("rst_out_valid", 64'(out_valid_a), 64'd0);
    check("rst_out_data", 64'(out_data_a), 64'd0);
    check("rst_out_ovf", 64'(out_ovf_a), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);

    // Basic job: 5+1+2+3+4 = 15.
    q = {16'd1, 16'd2, 16'd3, 16'd4};
    run_job(16'd5, 0, 0, 1'b0, 1'b0);

    // Gapped input and held output: -2-3+7 = 2.
    q = {16'hFFFE, 16'hFFFD, 16'd7};
    run_job(16'd0, 2, 5, 1'b0, 1'b0);

    // Zero length returns the sign-extended bias.
    q.delete();
    run_job(16'hFFF9, 0, 1, 1'b0, 1'b0);

    // Saturates the 17-bit instance, then a clean job clears the flag.
    q = {16'd32767, 16'd32767, 16'd32767};
    run_job(16'd32767, 0, 1, 1'b0, 1'b0);
    q = {16'd1};
    run_job(16'd0, 0, 0, 1'b0, 1'b0);

    // Start pulses during ACC and in the handshake cycle are ignored;
    // the immediately following job starts one cycle later.
    q = {16'd10, 16'd20};
    run_job(16'd0, 0, 0, 1'b1, 1'b1);
    q = {16'd6};
    run_job(16'd3, 0, 0, 1'b0, 1'b0);

    // Reset in the middle of a job.
    cfg_bias = 16'd100;
    cfg_len  = 8'd4;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 16'd50;
      tick();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    check("midrst_busy", 64'(busy_a), 64'd0);
    check("midrst_in_ready", 64'(in_ready_a), 64'd0);
    check("midrst_out_valid", 64'(out_valid_a), 64'd0);
    check("midrst_out_data", 64'(out_data_a), 64'd0);
    check("midrst_out_ovf", 64'(out_ovf_b), 64'd0);
    tick();
    check("midrst_no_valid", 64'(out_valid_b), 64'd0);
    q = {16'd9};
    run_job(16'd0, 0, 0, 1'b0, 1'b0);

    // Randomized jobs.
    for (int j = 0; j < 12; j++) begin
      int n;
      n = int'($urandom_range(0, 6));
      q.delete();
      for (int k = 0; k < n; k++) q.push_back(16'($urandom));
      run_job(16'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mlu_acc_stage.md
Name: mlu_acc_stage

Overview:
- Sits directly downstream of the 16-input adder tree in the PuDianNao MLU datapath.
- Consumes one tree sum per cycle over a valid/ready handshake and accumulates a programmed number of sums onto a bias into a wide signed accumulator.
- Emits one saturated result per job, held until the downstream ALU or output buffer accepts it.
- Provides the multi-cycle reduction that the combinational tree cannot.

Parameters:
- WIDTH, 16, width of the adder-tree sum and bias (signed two's complement)
- ACC_WIDTH, 32, accumulator and result width (signed); must be > WIDTH
- LEN_WIDTH, 8, width of the job-length field

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  job start pulse; sampled only in IDLE
- cfg_len  input  LEN_WIDTH  number of tree sums in the job; latched on accepted start
- cfg_bias  input  WIDTH  initial accumulator value, sign-extended; latched on accepted start
- in_valid  input  1  tree sum valid
- in_ready  output  1  stage accepts a tree sum
- in_data  input  WIDTH  signed tree sum
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  ACC_WIDTH  signed accumulated result
- out_ovf  output  1  sticky saturation flag for the job; valid with out_valid
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset, synchronous with rst=1 at a clk edge:
  - state=IDLE; acc, count, out_data all 0.
  - in_ready=0, out_valid=0, out_ovf=0, busy=0.
  - Reset mid-job drops the job silently; no partial result is emitted.
- FSM states: IDLE, ACC, OUT.
- IDLE:
  - start=1 loads acc=sign_ext(cfg_bias), count=0, len=cfg_len, ovf=0.
  - Next state is ACC if cfg_len!=0, otherwise OUT. For a zero-length job, out_data is the sign-extended bias on the next cycle.
- ACC:
  - in_ready=1 (registered state decode; in_ready does not depend on in_valid).
  - A transfer occurs when in_valid && in_ready: acc <= sat(acc + sign_ext(in_data)), count <= count+1.
  - When the transfer has count==len-1, next state is OUT and out_data <= the same saturated sum.
  - in_valid=0 cycles stall with no change. There is no timeout.
- OUT:
  - out_valid=1, in_ready=0.
  - out_data and out_ovf remain stable until out_valid && out_ready, then the state returns to IDLE.
  - out_ready is ignored outside OUT.
- start outside IDLE is ignored and not queued.
- A start in the same cycle as the OUT handshake is ignored, because state is still OUT. A new job may start at the earliest on the following cycle.
- Latency: the last accepted sum at edge t produces out_valid high after edge t (visible in cycle t+1). Throughput is 1 sum/cycle inside a job, plus 2 cycles of overhead per job (start and result).
- Arithmetic:
  - The add is signed at ACC_WIDTH+1 bits.
  - If the true sum exceeds 2^(ACC_WIDTH-1)-1 or falls below -2^(ACC_WIDTH-1), clamp to that limit and set ovf.
  - ovf is sticky until the next start. Accumulation continues from the clamped value.
- count wrap: len max is 2^LEN_WIDTH-1 and count never exceeds len-1, so no wrap occurs.
- All outputs are registered or decoded from state. There is no combinational path from in_valid or out_ready to any output.

Decomposition:
- Shared package mlu_pkg:
  - state enum acc_state_e {IDLE, ACC, OUT}
  - default constants MLU_WIDTH=16, MLU_ACC_WIDTH=32, MLU_LEN_WIDTH=8
  - function sat_add_signed(a,b) returning {ovf, sum}
- One natural sub-module, mlu_sat_adder: combinational signed saturating adder, WIDTH-extended input onto an ACC_WIDTH operand. It is reused by the ALU stage.
- FSM, counter and output register stay in mlu_acc_stage.

Test Plan:
- Basic job: bias=5, len=4, in_data 1,2,3,4 on consecutive cycles with out_ready=1 -> out_valid one cycle after the 4th transfer, out_data=15, out_ovf=0, back to IDLE next cycle.
- Stalls/backpressure: len=3, data -2,-3,7 with in_valid gaps of 2 cycles, out_ready held 0 for 5 cycles -> out_data=2 stable all 5 cycles, in_ready=0 during OUT, single handshake clears.
- Zero length: start with len=0, bias=-7 -> no input accepted, out_valid next cycle with out_data=-7 sign-extended (0xFFFFFFF9).
- Saturation (ACC_WIDTH=17 instance): bias=32767, len=3, data 32767 x3 -> out_data=65535, out_ovf=1. Next job bias=0, len=1, data=1 -> out_data=1, out_ovf=0.
- Ignored start: pulse start with len=9 during ACC of a len=2 job (data 10,20) -> result 30. Back-to-back start in the OUT-handshake cycle is ignored; start one cycle later is accepted.
- Reset mid-job: rst=1 after 2 of 4 transfers -> next cycle all outputs 0, state IDLE, no out_valid. A fresh job bias=0, len=1, data=9 -> out_data=9.
